// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types, constants and helpers for the multi-channel clock divider
package clkdiv_pkg;

    localparam int DEF_DIV_W = 8;
    localparam int MIN_DIV   = 2;

    typedef logic [DEF_DIV_W-1:0] div_t;

    // Length of the high phase for ratio n; odd ratios get the extra cycle high.
    function automatic logic [31:0] hi_len(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel with glitch-free ratio switching at period boundaries
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             pend_o,
    output logic             div_clk_o,
    output logic             tick_o
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             en_q;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             restart;

    // A restart point is any edge where a new period may legally begin.
    always_comb begin
        restart    = !en_i || !en_q || sync_i || (cnt_q == ratio_q - ONE);
        ratio_d    = (pend_q && restart) ? pend_div_q : ratio_q;
        pend_d     = wr_i ? 1'b1 : (restart ? 1'b0 : pend_q);
        pend_div_d = wr_i ? wr_div_i : pend_div_q;
        cnt_d      = restart ? '0 : cnt_q + ONE;
        div_clk_d  = en_i && (32'(cnt_d) < hi_len(32'(ratio_d)));
        tick_d     = en_i && (cnt_d == ratio_d - ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            ratio_q    <= DIV_W'(DEF_DIV);
            pend_div_q <= DIV_W'(DEF_DIV);
            pend_q     <= 1'b0;
            en_q       <= 1'b0;
            div_clk_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            en_q       <= en_i;
            div_clk_q  <= div_clk_d;
            tick_q     <= tick_d;
        end
    end

    assign pend_o    = pend_q;
    assign div_clk_o = div_clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clkdiv_multi_prog.sv
// rtl/clkdiv_multi_prog.sv - NUM_CH programmable clock dividers with shared config port and sync
module clkdiv_multi_prog
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;
    logic              ch_ok, div_ok, accept;
    logic              err_q;

    always_comb begin
        ch_ok     = 32'(cfg_ch) < NUM_CH;
        div_ok    = 32'(cfg_div) >= MIN_DIV;
        cfg_ready = ch_ok ? !pend[cfg_ch] : 1'b1;
        accept    = cfg_valid && cfg_ready;
    end

    // Rejected writes still complete the handshake; they only raise cfg_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= accept && !(ch_ok && div_ok);
    end

    assign cfg_err = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = accept && ch_ok && div_ok && (cfg_ch == CH_W'(i));

        clkdiv_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (reset),
            .en_i      (ch_en[i]),
            .sync_i    (sync),
            .wr_i      (wr[i]),
            .wr_div_i  (cfg_div),
            .pend_o    (pend[i]),
            .div_clk_o (div_clk[i]),
            .tick_o    (tick[i])
        );
    end

endmodule
